fetch_pc_unit: RTL and testbench

//  Parametrised next-generation program counter for the MIPS fetch stage. Holds the PC and

---
 rtl/fetch_pc_unit_pkg.sv | 27 ++
 rtl/fetch_pc_unit_return_stack.sv | 69 ++++++
 rtl/fetch_pc_unit.sv | 124 ++++++++++++
 tb/tb_fetch_pc_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch PC unit: vector defaults, FSM states,
// jump index field positions and the next-PC source select.
package fetch_pc_unit_pkg;

  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
  localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;

  // Jump index field inside the instruction word
  localparam int JIDX_MSB = 25;
  localparam int JIDX_LSB = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    SEL_HOLD   = 3'd0,
    SEL_SEQ    = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_JREG   = 3'd4,
    SEL_EXC    = 3'd5
  } pc_sel_t;

endpackage

// File: rtl/fetch_pc_unit_return_stack.sv
// Return-address stack: circular buffer whose write pointer wraps on
// overflow (oldest entry lost) and whose occupancy count saturates at DEPTH.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PW-1:0]    ptr;      // next free slot
  logic [PW-1:0]    top_idx;  // most recent entry
  logic [CW-1:0]    count;
  logic [PW-1:0]    wr_idx;

  assign top_idx = ptr - PW'(1);
  assign empty   = (count == '0);
  assign top     = empty ? '0 : entries[top_idx];
  // push+pop on a non-empty stack rewrites the top in place
  assign wr_idx  = (pop && !empty) ? top_idx : ptr;

  // Entry storage; no reset needed since count gates visibility
  always_ff @(posedge clk) begin
    if (push) entries[wr_idx] <= din;
  end

  // Pointer, occupancy and status flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      underflow <= 1'b0;
      if (push && pop) begin
        // replacing the top of an empty stack degenerates to a plain push
        if (empty) begin
          ptr   <= ptr + PW'(1);
          count <= CW'(1);
        end
      end else if (push) begin
        ptr <= ptr + PW'(1);
        if (count == FULL) overflow <= 1'b1;
        else               count    <= count + CW'(1);
      end else if (pop) begin
        if (empty) begin
          underflow <= 1'b1;
        end else begin
          ptr   <= ptr - PW'(1);
          count <= count - CW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage program counter: prioritised next-PC selection, valid/ready
// throttling, halt, and a return-address stack fed by jal/jalr/jr $ra.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 32,
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter logic [31:0] EXC_VECTOR   = DEF_EXC_VECTOR,
  parameter int          RAS_DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fetch_ready,
  output logic                  fetch_valid,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus4,
  input  logic [31:0]           instruction,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_offset,
  input  logic                  jump,
  input  logic                  link,
  input  logic                  jump_reg,
  input  logic [ADDR_WIDTH-1:0] jump_reg_target,
  input  logic                  ret,
  input  logic                  exception,
  input  logic                  halt,
  output logic [ADDR_WIDTH-1:0] ras_top,
  output logic                  ras_empty,
  output logic                  ras_overflow,
  output logic                  ras_underflow
);

  localparam int AW = ADDR_WIDTH;
  localparam logic [AW-1:0] RST_PC = AW'(RESET_VECTOR);
  localparam logic [AW-1:0] EXC_PC = AW'(EXC_VECTOR);

  state_t        state, state_next;
  pc_sel_t       pc_sel;
  logic [AW-1:0] pc_next;
  logic [AW-1:0] branch_target, jump_target, jreg_target;
  logic          fire, ras_push, ras_pop;
  logic          unused_bits;

  assign pc_plus4      = pc + AW'(4);
  assign branch_target = pc_plus4 + {branch_offset[AW-3:0], 2'b00};
  assign jump_target   = {pc_plus4[AW-1:28], instruction[JIDX_MSB:JIDX_LSB], 2'b00};
  assign jreg_target   = {jump_reg_target[AW-1:2], 2'b00};
  assign fire          = fetch_valid & fetch_ready;
  assign unused_bits   = ^{instruction[31:26], jump_reg_target[1:0], branch_offset[AW-1:AW-2]};

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: one idle cycle after reset, then run until halt
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = RUN;
      RUN:     if (halt) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // Outputs: only RUN issues fetches
  always_comb begin
    fetch_valid = (state == RUN);
  end

  // Redirect priority; redirects override a stall. The fetch offered in the
  // halting cycle is abandoned, so halt suppresses the sequential advance.
  always_comb begin
    pc_sel = SEL_HOLD;
    if (state == RUN) begin
      if      (exception)    pc_sel = SEL_EXC;
      else if (jump_reg)     pc_sel = SEL_JREG;
      else if (jump)         pc_sel = SEL_JUMP;
      else if (branch_taken) pc_sel = SEL_BRANCH;
      else if (fire && !halt) pc_sel = SEL_SEQ;
    end
  end

  // Next-PC mux
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      SEL_EXC:    pc_next = EXC_PC;
      SEL_JREG:   pc_next = jreg_target;
      SEL_JUMP:   pc_next = jump_target;
      SEL_BRANCH: pc_next = branch_target;
      SEL_SEQ:    pc_next = pc_plus4;
      default:    pc_next = pc;
    endcase
  end

  // PC register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RST_PC;
    else        pc <= pc_next;
  end

  // Return stack acts only when a jump or jump-register wins
  assign ras_push = link & ((pc_sel == SEL_JUMP) | (pc_sel == SEL_JREG));
  assign ras_pop  = ret & (pc_sel == SEL_JREG);

  return_stack #(
    .DEPTH (RAS_DEPTH),
    .WIDTH (AW)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .din       (pc_plus4),
    .top       (ras_top),
    .empty     (ras_empty),
    .overflow  (ras_overflow),
    .underflow (ras_underflow)
  );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: a vector table for the PC datapath and
// priority, plus hand sequences for the return stack, halt and reset.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_ready, fetch_valid;
  logic [31:0] pc, pc_plus4, instruction, branch_offset, jump_reg_target, ras_top;
  logic        branch_taken, jump, link, jump_reg, ret, exception, halt;
  logic        ras_empty, ras_overflow, ras_underflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(
    .ADDR_WIDTH   (32),
    .RESET_VECTOR (32'h0),
    .EXC_VECTOR   (32'h8000_0180),
    .RAS_DEPTH    (4)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_ready     (fetch_ready),
    .fetch_valid     (fetch_valid),
    .pc              (pc),
    .pc_plus4        (pc_plus4),
    .instruction     (instruction),
    .branch_taken    (branch_taken),
    .branch_offset   (branch_offset),
    .jump            (jump),
    .link            (link),
    .jump_reg        (jump_reg),
    .jump_reg_target (jump_reg_target),
    .ret             (ret),
    .exception       (exception),
    .halt            (halt),
    .ras_top         (ras_top),
    .ras_empty       (ras_empty),
    .ras_overflow    (ras_overflow),
    .ras_underflow   (ras_underflow)
  );

  typedef struct {
    logic        rdy, br, jmp, jr, lnk, rt, exc;
    logic [31:0] off, instr, jrt;
    logic [31:0] exp_pc;
    logic        exp_fv, exp_empty;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic rdy, br, jmp, jr, lnk, rt, exc,
                              input logic [31:0] off, instr, jrt, exp_pc,
                              input logic exp_fv, exp_empty);
    vec_t v;
    v.rdy = rdy; v.br = br; v.jmp = jmp; v.jr = jr; v.lnk = lnk; v.rt = rt; v.exc = exc;
    v.off = off; v.instr = instr; v.jrt = jrt;
    v.exp_pc = exp_pc; v.exp_fv = exp_fv; v.exp_empty = exp_empty;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    fetch_ready = 1'b0; instruction = '0; branch_taken = 1'b0; branch_offset = '0;
    jump = 1'b0; link = 1'b0; jump_reg = 1'b0; jump_reg_target = '0;
    ret = 1'b0; exception = 1'b0; halt = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] model_pc;
  logic [31:0] exp_ret [5];
  logic [31:0] exp_pop_top [4];

  initial begin
    vecs[0]  = mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_0000, 1, 1);
    vecs[1]  = mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_0004, 1, 1);
    vecs[2]  = mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_0008, 1, 1);
    vecs[3]  = mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_0008, 1, 1);
    vecs[4]  = mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_0008, 1, 1);
    vecs[5]  = mk(0,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_0008, 1, 1);
    vecs[6]  = mk(0,1,0,0,0,0,0, 32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0000_0004, 1, 1);
    vecs[7]  = mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_0008, 1, 1);
    vecs[8]  = mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h0000_000C, 1, 1);
    vecs[9]  = mk(0,0,0,1,0,0,0, 32'h0, 32'h0, 32'h0FFF_FFF3, 32'h0FFF_FFF0, 1, 1);
    vecs[10] = mk(0,0,1,0,0,0,0, 32'h0, 32'h0000_0040, 32'h0, 32'h0000_0100, 1, 1);
    vecs[11] = mk(1,1,0,1,1,1,1, 32'h5, 32'h0, 32'h0000_0500, 32'h8000_0180, 1, 1);
    vecs[12] = mk(1,0,0,0,0,0,0, 32'h0, 32'h0, 32'h0, 32'h8000_0184, 1, 1);
    vecs[13] = mk(1,1,1,0,0,0,0, 32'h5, 32'h0000_0800, 32'h0, 32'h8000_2000, 1, 1);
    vecs[14] = mk(0,0,1,1,0,0,0, 32'h0, 32'h0000_0040, 32'h0000_1000, 32'h0000_1000, 1, 1);

    // Reset state
    idle_inputs();
    reset = 1'b0;
    #2;
    check("reset_pc", pc, 32'h0);
    check("reset_fv", {31'b0, fetch_valid}, 32'h0);
    check("reset_ras_empty", {31'b0, ras_empty}, 32'h1);
    check("reset_ras_top", ras_top, 32'h0);
    check("reset_ovf", {31'b0, ras_overflow}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("idle_fv", {31'b0, fetch_valid}, 32'h0);

    // Table-driven datapath and priority vectors
    for (int i = 0; i < 15; i++) begin
      fetch_ready = vecs[i].rdy; branch_taken = vecs[i].br; jump = vecs[i].jmp;
      jump_reg = vecs[i].jr; link = vecs[i].lnk; ret = vecs[i].rt; exception = vecs[i].exc;
      branch_offset = vecs[i].off; instruction = vecs[i].instr; jump_reg_target = vecs[i].jrt;
      tick();
      $display("[TB] vec %0d pc=%h fv=%0b ras_empty=%0b", i, pc, fetch_valid, ras_empty);
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_fv", i), {31'b0, fetch_valid}, {31'b0, vecs[i].exp_fv});
      check($sformatf("vec%0d_ras_empty", i), {31'b0, ras_empty}, {31'b0, vecs[i].exp_empty});
      check($sformatf("vec%0d_underflow", i), {31'b0, ras_underflow}, 32'h0);
    end
    idle_inputs();

    // Five jal pushes into a four-deep stack
    model_pc = 32'h0000_1000;
    for (int i = 0; i < 5; i++) begin
      logic [31:0] tgt;
      tgt = 32'h0000_2000 + 32'h100 * i;
      exp_ret[i] = model_pc + 32'h4;
      jump = 1'b1; link = 1'b1; instruction = {6'b0, tgt[27:2]};
      tick();
      model_pc = tgt;
      $display("[TB] jal %0d pc=%h ras_top=%h ovf=%0b", i, pc, ras_top, ras_overflow);
      check($sformatf("jal%0d_pc", i), pc, tgt);
      check($sformatf("jal%0d_top", i), ras_top, exp_ret[i]);
      check($sformatf("jal%0d_ovf", i), {31'b0, ras_overflow}, (i == 4) ? 32'h1 : 32'h0);
    end
    idle_inputs();
    check("ras_top_after_ovf", ras_top, 32'h0000_2304);

    // Four jr $ra pops drain the surviving entries, newest first
    exp_pop_top[0] = 32'h0000_2204;
    exp_pop_top[1] = 32'h0000_2104;
    exp_pop_top[2] = 32'h0000_2004;
    exp_pop_top[3] = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      jump_reg = 1'b1; ret = 1'b1; jump_reg_target = 32'h0000_3000;
      tick();
      $display("[TB] ret %0d pc=%h ras_top=%h empty=%0b", i, pc, ras_top, ras_empty);
      check($sformatf("ret%0d_top", i), ras_top, exp_pop_top[i]);
      check($sformatf("ret%0d_underflow", i), {31'b0, ras_underflow}, 32'h0);
    end
    check("ras_empty_after_pops", {31'b0, ras_empty}, 32'h1);
    // Fifth pop underflows for exactly one cycle
    tick();
    $display("[TB] ret 4 underflow=%0b", ras_underflow);
    check("pop_empty_underflow", {31'b0, ras_underflow}, 32'h1);
    check("pop_empty_still_empty", {31'b0, ras_empty}, 32'h1);
    idle_inputs();
    tick();
    check("underflow_pulse_end", {31'b0, ras_underflow}, 32'h0);
    check("overflow_sticky", {31'b0, ras_overflow}, 32'h1);

    // jalr to 20, then halt there
    jump_reg = 1'b1; link = 1'b1; jump_reg_target = 32'h0000_0014;
    tick();
    idle_inputs();
    check("jalr_pc", pc, 32'h0000_0014);
    check("jalr_top", ras_top, 32'h0000_3004);
    fetch_ready = 1'b1; halt = 1'b1;
    tick();
    $display("[TB] halt pc=%h fv=%0b", pc, fetch_valid);
    check("halt_pc", pc, 32'h0000_0014);
    check("halt_fv", {31'b0, fetch_valid}, 32'h0);
    halt = 1'b0; exception = 1'b1; branch_taken = 1'b1; branch_offset = 32'h10;
    jump = 1'b1; link = 1'b1;
    tick();
    tick();
    check("halted_ignores_redirect", pc, 32'h0000_0014);
    check("halted_fv", {31'b0, fetch_valid}, 32'h0);
    check("halted_ras_kept", {31'b0, ras_empty}, 32'h0);

    // Asynchronous reset between edges
    #2;
    reset = 1'b0;
    #1;
    $display("[TB] async reset pc=%h empty=%0b", pc, ras_empty);
    check("async_reset_pc", pc, 32'h0);
    check("async_reset_ras_empty", {31'b0, ras_empty}, 32'h1);
    check("async_reset_ovf", {31'b0, ras_overflow}, 32'h0);
    idle_inputs();
    @(negedge clk);
    reset = 1'b1;
    fetch_ready = 1'b1;
    tick();
    tick();
    check("restart_pc", pc, 32'h0000_0004);
    // Exception together with halt: exception loads pc, FSM halts
    exception = 1'b1; halt = 1'b1;
    tick();
    idle_inputs();
    fetch_ready = 1'b1;
    $display("[TB] exc+halt pc=%h fv=%0b", pc, fetch_valid);
    check("exc_halt_pc", pc, 32'h8000_0180);
    check("exc_halt_fv", {31'b0, fetch_valid}, 32'h0);
    tick();
    check("exc_halt_frozen", pc, 32'h8000_0180);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
